// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: state encoding, default sizes
// and a ceil-log2 helper used to size the step counter.
package serial_adder_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DIGIT = 2;

   // Ceiling log2, never less than 1 so a single-step build still has a counter bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/serial_adder_add_slice.sv
// add_slice: combinational DIGIT-bit ripple adder built from chained full-adder cells.
module add_slice #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co
);

   logic c;

   // NOTE: every output of a combinational block gets a value before the loop,
   // otherwise a path that skips an assignment infers a latch.
   always_comb begin
      c = ci;
      s = '0;
      for (int i = 0; i < DIGIT; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      co = c;
   end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: adds a + b + cin DIGIT bits per clock, LSB first, with a start/busy/done
// handshake. Define SERIAL_ADDER_SUB_EN to add a 'sub' port computing a - b - cin.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIGIT = DEF_DIGIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = clog2(STEPS);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] wa, wb, acc, acc_next;
   logic             carry;
   logic [DIGIT-1:0] slice_s;
   logic             slice_co;
   logic [WIDTH-1:0] b_load;
   logic             cin_load;
   logic             last_step;

`ifdef SERIAL_ADDER_SUB_EN
   // Subtraction as a + ~b + ~cin; a final carry of 1 means no borrow.
   assign b_load   = sub ? ~b : b;
   assign cin_load = cin ^ sub;
`else
   assign b_load   = b;
   assign cin_load = cin;
`endif

   add_slice #(.DIGIT(DIGIT)) u_slice (
      .x  (wa[DIGIT-1:0]),
      .y  (wb[DIGIT-1:0]),
      .ci (carry),
      .s  (slice_s),
      .co (slice_co)
   );

   // New sum digits enter at the MSB end so the result is aligned after STEPS shifts.
   assign acc_next  = WIDTH'({slice_s, acc} >> DIGIT);
   assign last_step = (cnt == CW'(STEPS - 1));

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         wa    <= '0;
         wb    <= '0;
         acc   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  wa    <= a;
                  wb    <= b_load;
                  carry <= cin_load;
                  cnt   <= '0;
                  acc   <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               wa    <= wa >> DIGIT;
               wb    <= wb >> DIGIT;
               carry <= slice_co;
               acc   <= acc_next;
               if (last_step) begin
                  sum   <= acc_next;
                  cout  <= slice_co;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
